// File: rtl/bcd_pkg.sv
// Shared constants, FSM state type and code-check helper for the BCD scanner.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package bcd_pkg;

  localparam logic [3:0] BCD_MAX = 4'd9;
  localparam logic [9:0] BLANK   = 10'h3FF;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } state_t;

  // True when a nibble is not a legal decimal digit.
  function automatic logic bad_code(input logic [3:0] code);
    return code > BCD_MAX;
  endfunction

endpackage

// File: rtl/bcd_decimal_scanner_dec1.sv
// Single-digit decoder: 4-bit code to 10-bit active-low one-hot.
// Latency: combinational.
// Backpressure: none; illegal codes (>9) decode to all ones.
module bcd_dec1
  import bcd_pkg::*;
(
  input  logic [3:0] code,
  output logic [9:0] dec
);

  // Clear exactly one bit for a legal digit, leave everything high otherwise.
  always_comb begin
    dec = BLANK;
    if (!bad_code(code)) begin
      dec = ~(10'd1 << code);
    end
  end

endmodule

// File: rtl/bcd_decimal_scanner.sv
// Multiplexed BCD display scanner with a one-word shadow buffer and frame-aligned commit.
// Latency: outputs registered one cycle behind the digit index; first frame starts the cycle after the first accept.
// Backpressure: in_ready is low while a word waits in the shadow register, until the next frame wrap.
module bcd_decimal_scanner
  import bcd_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter int SCAN_DIV = 1000,
  parameter int LZB      = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  input  logic [4*DIGITS-1:0] in_bcd,
  output logic                in_ready,
  output logic [9:0]          dec_out,
  output logic [DIGITS-1:0]   dig_sel,
  output logic                err
);

  localparam int W  = 4 * DIGITS;
  localparam int PW = ($clog2(SCAN_DIV) > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = ($clog2(DIGITS) > 1) ? $clog2(DIGITS) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);

  state_t              state;
  state_t              state_nxt;
  logic [W-1:0]        shadow;
  logic [W-1:0]        disp;
  logic                pending;
  logic [PW-1:0]       presc;
  logic [IW-1:0]       idx;
  logic                accept;
  logic                presc_tc;
  logic                wrap;
  logic                commit;
  logic                shadow_err;
  logic [3:0]          sel_code;
  logic                upper_zero;
  logic                blank;
  logic [9:0]          dec_sel;
  logic [9:0]          dec_out_nxt;
  logic [DIGITS-1:0]   dig_sel_nxt;

  assign in_ready = ~pending;
  assign accept   = in_valid & in_ready;
  assign presc_tc = (state == ST_SCAN) && (presc == PRESC_LAST);
  assign wrap     = presc_tc && (idx == IDX_LAST);
  // The first word goes straight to the display; later words only at a frame wrap.
  assign commit   = pending && ((state == ST_IDLE) || wrap);

  // Any illegal nibble in the word about to be committed raises err.
  always_comb begin
    shadow_err = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      shadow_err = shadow_err | bad_code(shadow[4*i +: 4]);
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next state: leave IDLE once a word is buffered; SCAN is only left by reset.
  always_comb begin
    state_nxt = state;
    if (state == ST_IDLE && pending) state_nxt = ST_SCAN;
  end

  // Shadow buffer, display register, error flag and scan counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow  <= '0;
      disp    <= '0;
      pending <= 1'b0;
      err     <= 1'b0;
      presc   <= '0;
      idx     <= '0;
    end else begin
      if (accept) shadow <= in_bcd;
      // A same-edge accept keeps the new word pending; the commit takes the old shadow.
      if (accept)      pending <= 1'b1;
      else if (commit) pending <= 1'b0;
      if (commit) begin
        disp <= shadow;
        err  <= shadow_err;
      end
      if (state == ST_IDLE) begin
        presc <= '0;
        idx   <= '0;
      end else if (presc_tc) begin
        presc <= '0;
        idx   <= wrap ? '0 : idx + 1'b1;
      end else begin
        presc <= presc + 1'b1;
      end
    end
  end

  // Select the current digit and decide whether it is a blanked leading zero.
  always_comb begin
    sel_code   = 4'd0;
    upper_zero = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx == IW'(i)) sel_code = disp[4*i +: 4];
      if (IW'(i) >= idx && disp[4*i +: 4] != 4'd0) upper_zero = 1'b0;
    end
    blank = (LZB != 0) && (idx != '0) && upper_zero;
  end

  bcd_dec1 u_dec1 (
    .code (sel_code),
    .dec  (dec_sel)
  );

  // Output decode: all ones in IDLE, otherwise one enabled digit and its value.
  always_comb begin
    dig_sel_nxt = '1;
    dec_out_nxt = BLANK;
    if (state == ST_SCAN) begin
      for (int i = 0; i < DIGITS; i++) begin
        dig_sel_nxt[i] = (idx != IW'(i));
      end
      dec_out_nxt = blank ? BLANK : dec_sel;
    end
  end

  // Register the display drive so select and value switch on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dig_sel <= '1;
      dec_out <= BLANK;
    end else begin
      dig_sel <= dig_sel_nxt;
      dec_out <= dec_out_nxt;
    end
  end

endmodule

// File: tb/tb_bcd_decimal_scanner.sv
// Directed bench for bcd_decimal_scanner with DIGITS=4, SCAN_DIV=4, LZB=1.
// Each frame is 16 cycles; samples are taken 1 time unit after the rising edge.
// Stream phase uses a scoreboard of accepted words against the displayed frames.
module tb_bcd_decimal_scanner;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] in_bcd = 16'h0;
  logic        in_ready;
  logic [9:0]  dec_out;
  logic [3:0]  dig_sel;
  logic        err;

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] ws [10];
  int          ws_idx = 0;
  logic [15:0] sb [$];

  bcd_decimal_scanner #(
    .DIGITS   (4),
    .SCAN_DIV (4),
    .LZB      (1)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_bcd   (in_bcd),
    .in_ready (in_ready),
    .dec_out  (dec_out),
    .dig_sel  (dig_sel),
    .err      (err)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected dec_out per digit for a displayed word, digit 0 in bits [9:0].
  function automatic logic [39:0] model_frame(input logic [15:0] w);
    logic [39:0] r;
    logic [3:0]  c;
    logic [15:0] up;
    r = '0;
    for (int d = 0; d < 4; d++) begin
      c  = w[4*d +: 4];
      up = w >> (4*d);
      r[10*d +: 10] = (c > 4'd9 || (d != 0 && up == 16'h0)) ? 10'h3FF : ~(10'd1 << c);
    end
    return r;
  endfunction

  task automatic do_reset;
    in_valid = 1'b0;
    rst_n    = 1'b0;
    tick;
    tick;
    rst_n = 1'b1;
  endtask

  // Source stepping with in_valid held: advance to the next word after each accept.
  task automatic stream_step(output bit fired);
    fired = in_valid && in_ready;
    tick;
    if (fired) begin
      sb.push_back(in_bcd);
      ws_idx++;
      if (ws_idx < 10) in_bcd = ws[ws_idx];
      else             in_valid = 1'b0;
    end
  endtask

  // First word from IDLE: accept edge, then the transition edge.
  task automatic send_idle(input string tag, input logic [15:0] w);
    in_valid = 1'b1;
    in_bcd   = w;
    tick;
    in_valid = 1'b0;
    chk({tag, " ready after accept"}, {15'h0, in_ready}, 16'h0);
    tick;
    chk({tag, " sel during transition"}, {12'h0, dig_sel}, 16'h000F);
  endtask

  // One 16-cycle frame: digit k/4 enabled for 4 cycles each, with optional mid-frame word.
  task automatic frame(input string tag, input logic [39:0] exp, input bit inject,
                       input logic [15:0] inj_word, input bit stream, input logic exp_err,
                       output int n_acc);
    bit         fired;
    logic [3:0] exp_sel;
    n_acc = 0;
    for (int k = 0; k < 16; k++) begin
      if (stream) begin
        stream_step(fired);
        if (fired) n_acc++;
      end else begin
        tick;
      end
      exp_sel = ~(4'b0001 << (k / 4));
      chk($sformatf("%s dig_sel k%0d", tag, k), {12'h0, dig_sel}, {12'h0, exp_sel});
      chk($sformatf("%s dec_out k%0d", tag, k), {6'h0, dec_out}, {6'h0, exp[10*(k/4) +: 10]});
      if (k == 7) chk($sformatf("%s err", tag), {15'h0, err}, {15'h0, exp_err});
      if (inject) begin
        if (k >= 4) chk($sformatf("%s in_ready k%0d", tag, k), {15'h0, in_ready}, {15'h0, (k == 15)});
        if (k == 3) begin
          in_valid = 1'b1;
          in_bcd   = inj_word;
        end
        if (k == 4) in_valid = 1'b0;
      end
    end
  endtask

  initial begin
    int          n_acc;
    bit          fired;
    logic [15:0] exp_w;

    ws[0] = 16'h9876; ws[1] = 16'h0012; ws[2] = 16'h3000; ws[3] = 16'h0405;
    ws[4] = 16'h1111; ws[5] = 16'h0000; ws[6] = 16'h2468; ws[7] = 16'h0009;
    ws[8] = 16'h7531; ws[9] = 16'h1002;

    // Reset state.
    do_reset;
    chk("reset in_ready", {15'h0, in_ready}, 16'h0001);
    chk("reset dig_sel",  {12'h0, dig_sel},  16'h000F);
    chk("reset dec_out",  {6'h0, dec_out},   16'h03FF);
    chk("reset err",      {15'h0, err},      16'h0000);
    repeat (5) tick;
    chk("idle stays blank", {12'h0, dig_sel}, 16'h000F);

    // Basic scan of 1234, two frames with no new word.
    send_idle("s1", 16'h1234);
    frame("s1f0", {10'h3FD, 10'h3FB, 10'h3F7, 10'h3EF}, 1'b0, 16'h0, 1'b0, 1'b0, n_acc);
    frame("s1f1", {10'h3FD, 10'h3FB, 10'h3F7, 10'h3EF}, 1'b0, 16'h0, 1'b0, 1'b0, n_acc);
    chk("s1 in_ready", {15'h0, in_ready}, 16'h0001);

    // Mid-frame update: no tearing, commit at the wrap.
    do_reset;
    send_idle("s2", 16'h1234);
    frame("s2f0", {10'h3FD, 10'h3FB, 10'h3F7, 10'h3EF}, 1'b1, 16'h5678, 1'b0, 1'b0, n_acc);
    frame("s2f1", {10'h3DF, 10'h3BF, 10'h37F, 10'h2FF}, 1'b0, 16'h0, 1'b0, 1'b0, n_acc);

    // Illegal code plus leading-zero blanking; a clean word clears err.
    do_reset;
    send_idle("s3", 16'h00A7);
    chk("s3 err after commit", {15'h0, err}, 16'h0001);
    frame("s3f0", {10'h3FF, 10'h3FF, 10'h3FF, 10'h37F}, 1'b1, 16'h0007, 1'b0, 1'b1, n_acc);
    frame("s3f1", {10'h3FF, 10'h3FF, 10'h3FF, 10'h37F}, 1'b0, 16'h0, 1'b0, 1'b0, n_acc);
    chk("s3 err cleared", {15'h0, err}, 16'h0000);

    // All-zero word: only digit 0 shows.
    do_reset;
    send_idle("s4", 16'h0000);
    frame("s4f0", {10'h3FF, 10'h3FF, 10'h3FF, 10'h3FE}, 1'b0, 16'h0, 1'b0, 1'b0, n_acc);

    // Reset in digit 2 with a word pending.
    do_reset;
    send_idle("s5", 16'h1234);
    repeat (4) tick;
    in_valid = 1'b1;
    in_bcd   = 16'h5678;
    tick;
    in_valid = 1'b0;
    chk("s5 pending", {15'h0, in_ready}, 16'h0000);
    repeat (4) tick;
    chk("s5 on digit 2", {12'h0, dig_sel}, 16'h000B);
    rst_n = 1'b0;
    #1;
    chk("s5 async dig_sel",  {12'h0, dig_sel},  16'h000F);
    chk("s5 async dec_out",  {6'h0, dec_out},   16'h03FF);
    chk("s5 async in_ready", {15'h0, in_ready}, 16'h0001);
    tick;
    tick;
    rst_n = 1'b1;
    repeat (20) tick;
    chk("s5 idle dig_sel",  {12'h0, dig_sel},  16'h000F);
    chk("s5 idle dec_out",  {6'h0, dec_out},   16'h03FF);
    chk("s5 idle in_ready", {15'h0, in_ready}, 16'h0001);
    send_idle("s5b", 16'h0042);
    frame("s5f0", {10'h3FF, 10'h3FF, 10'h3EF, 10'h3FB}, 1'b0, 16'h0, 1'b0, 1'b0, n_acc);

    // in_valid held high: one accept per frame, every word shown once in order.
    do_reset;
    ws_idx   = 0;
    in_valid = 1'b1;
    in_bcd   = ws[0];
    stream_step(fired);
    stream_step(fired);
    for (int f = 0; f < 10; f++) begin
      chk($sformatf("s6 sb depth f%0d", f), {15'h0, (sb.size() != 0)}, 16'h0001);
      exp_w = 16'h0;
      if (sb.size() != 0) exp_w = sb.pop_front();
      chk($sformatf("s6 order f%0d", f), exp_w, ws[f]);
      frame($sformatf("s6f%0d", f), model_frame(ws[f]), 1'b0, 16'h0, 1'b1, 1'b0, n_acc);
      chk($sformatf("s6 accepts f%0d", f), n_acc[15:0], (f < 9) ? 16'h0001 : 16'h0000);
    end
    chk("s6 words sent", ws_idx[15:0], 16'd10);
    chk("s6 sb drained", sb.size() == 0 ? 16'h1 : 16'h0, 16'h0001);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/bcd_decimal_scanner.md
BCD_DECIMAL_SCANNER -- requirements
Module: bcd_decimal_scanner

Interface
REQ-001 The block SHALL have parameter DIGITS, default 4, meaning the number of BCD digits (legal range 1..8).
REQ-002 The block SHALL have parameter SCAN_DIV, default 1000, meaning clock cycles per digit slot (legal range 2..65535).
REQ-003 The block SHALL have parameter LZB, default 1, meaning leading-zero blanking is enabled when 1.
REQ-004 The block SHALL have port clk, input, width 1: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst_n, input, width 1: asynchronous reset, active-low.
REQ-006 The block SHALL have port in_valid, input, width 1: the upstream word is valid.
REQ-007 The block SHALL have port in_bcd, input, width 4*DIGITS: packed BCD word, digit 0 at bits [3:0], digit 0 least significant.
REQ-008 The block SHALL have port in_ready, output, width 1: the block can accept a word.
REQ-009 The block SHALL have port dec_out, output, width 10: active-low one-hot decimal value of the selected digit, with bit k low meaning value k.
REQ-010 The block SHALL have port dig_sel, output, width DIGITS: active-low one-hot digit enable.
REQ-011 The block SHALL have port err, output, width 1: the displayed word contains a code greater than 9.

Function
REQ-012 The transfer rule SHALL be: a word is accepted on a clock edge where in_valid=1 and in_ready=1, and in_bcd is captured into a shadow register that sets the pending flag.
REQ-013 in_ready SHALL equal NOT pending, so that only one word is buffered at a time.
REQ-014 The FSM SHALL have states IDLE and SCAN; reset enters IDLE, and in IDLE dig_sel and dec_out are all ones.
REQ-015 IDLE->SCAN SHALL occur on the cycle after the first accept: the shadow copies to the display register, pending clears, the digit index is 0, and the prescaler is 0.
REQ-016 In SCAN, the prescaler SHALL count 0..SCAN_DIV-1; at the terminal count it wraps to 0 and the digit index advances, going from DIGITS-1 to 0.
REQ-017 A pending word SHALL commit to the display register only on the index wrap DIGITS-1->0, never mid-frame, so there is no tearing; pending clears on that same edge.
REQ-018 When an accept and a commit fall on the same edge, the commit SHALL take the prior shadow contents and the new word SHALL remain pending.
REQ-019 dig_sel and dec_out SHALL be registered and change on the same edge, one cycle after the index changes, for a latency of 1 cycle.
REQ-020 A digit code greater than 9 SHALL drive dec_out all ones while its dig_sel is still asserted.
REQ-021 With LZB=1, a zero digit SHALL be blanked (dec_out all ones) when it and all more-significant digits are zero; digit 0 is never blanked.
REQ-022 err SHALL be recomputed at each commit as the OR of (code>9) over the committed digits, and SHALL hold between commits.
REQ-023 The block SHALL never return to IDLE except by reset.

Reset
REQ-024 On rst_n=0, the block SHALL asynchronously set: state IDLE, pending 0, in_ready 1, prescaler 0, index 0, dig_sel all ones, dec_out all ones, err 0, and display and shadow registers 0.
REQ-025 Reset asserted mid-frame SHALL discard any pending word, with no output glitch beyond going to the all-ones outputs.

Structure
REQ-026 A shared package bcd_pkg SHALL hold the BCD_MAX=9 constant, the state enum type, and the 10-bit all-ones blank constant.
REQ-027 A combinational sub-module bcd_dec1 SHALL map a 4-bit code to a 10-bit active-low one-hot, returning all ones for codes greater than 9; exactly one instance is used on the selected digit.
REQ-028 The prescaler width SHALL be $clog2(SCAN_DIV) and the index width SHALL be $clog2(DIGITS), with a minimum of 1 bit each.

Verification
REQ-029 Scenario: DIGITS=4, SCAN_DIV=4; send 0x1234 after reset -> dig_sel walks 1110,1101,1011,0111, each for 4 cycles; dec_out low bits are 4,3,2,1 respectively; err=0.
REQ-030 Scenario: send 0x1234 then 0x5678 mid-frame -> in_ready drops for the remainder of the frame; the display shows 1234 until the wrap, then 5678; in_ready rises on the wrap edge.
REQ-031 Scenario: send 0x00A7 with LZB=1 -> digits 3 and 2 are blanked; digit 1 (code A) gives dec_out=0x3FF with dig_sel asserted; digit 0 shows 7; err=1 after the commit; a later 0x0007 clears err.
REQ-032 Scenario: send 0x0000 with LZB=1 -> only digit 0 shows 0 (dec_out=0x3FE); the others are blanked.
REQ-033 Scenario: assert rst_n low in the middle of digit 2 with a word pending -> outputs are all ones immediately, in_ready=1, and after release the block stays in IDLE until a new accept.
REQ-034 Scenario: hold in_valid high continuously -> exactly one accept per frame and no word lost or duplicated, checked by a scoreboard over 10 words.
